shift_register: RTL and testbench

SHIFT_REGISTER -- requirements
Module: shift_register

---
 rtl/shift_register_pkg.sv | 10 +
 rtl/shift_register.sv | 44 ++++
 tb/tb_shift_register.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared constants for the serial-in / parallel-out shift register.
package shift_register_pkg;

    // Default register width in bits.
    localparam int unsigned SHIFT_REG_DEFAULT_WIDTH = 8;

    // Default value loaded on reset; widened to WIDTH bits at the point of use.
    localparam int unsigned SHIFT_REG_DEFAULT_RESET_VALUE = 0;

endpackage : shift_register_pkg

// File: rtl/shift_register.sv
// Serial-in / parallel-out left-shift register with synchronous reset.
// New bits enter at bit 0. The bit leaving the top is dropped.
// The reset input is named reset_n but is active-high: 1 resets the register.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int unsigned      WIDTH       = SHIFT_REG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(SHIFT_REG_DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             shift_enable,
    output logic [WIDTH-1:0] data_out
);

    // A width below 2 leaves no bits to carry across a shift.
    if (WIDTH < 2) begin : g_width_check
        $error("shift_register: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next state: shift left when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (shift_enable) begin
            data_d = {data_q[WIDTH-2:0], data_in};
        end
    end

    // Register update; reset takes priority over shift and hold.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_shift_register;

    localparam int unsigned W    = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk;
    logic         reset_n;
    logic         data_in;
    logic         shift_enable;
    logic [W-1:0] data_out;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned model;

    shift_register #(
        .WIDTH       (W),
        .RESET_VALUE ('0)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .shift_enable (shift_enable),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Apply one edge of stimulus, advance the model, compare against it.
    task automatic step(input string tag, input logic rst, input logic en, input logic din);
        @(negedge clk);
        reset_n      = rst;
        shift_enable = en;
        data_in      = din;
        @(posedge clk);
        #1;
        if (rst) begin
            model = 0;
        end else if (en) begin
            model = ((model * 2) + int'(din)) & MASK;
        end
        check(tag, data_out, W'(model));
    endtask

    initial begin
        logic [7:0] pat;
        logic [W-1:0] held;
        n_cmp        = 0;
        n_bad        = 0;
        model        = 0;
        reset_n      = 1'b0;
        shift_enable = 1'b0;
        data_in      = 1'b0;

        // Reset held two edges with shift requested.
        step("reset0", 1'b1, 1'b1, 1'b1);
        check("reset0_const", data_out, 8'h00);
        step("reset1", 1'b1, 1'b1, 1'b1);
        check("reset1_const", data_out, 8'h00);

        // Shift 1,0,1,1 from zero.
        step("shift_a", 1'b0, 1'b1, 1'b1);
        check("shift_a_const", data_out, 8'h01);
        step("shift_b", 1'b0, 1'b1, 1'b0);
        check("shift_b_const", data_out, 8'h02);
        step("shift_c", 1'b0, 1'b1, 1'b1);
        check("shift_c_const", data_out, 8'h05);
        step("shift_d", 1'b0, 1'b1, 1'b1);
        check("shift_d_const", data_out, 8'h0B);

        // Hold with data_in toggling.
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, 1'(i % 2));
            check("hold_const", data_out, 8'h0B);
        end

        // Fill with ones, then one zero pushes the top bit out.
        for (int i = 0; i < 8; i++) begin
            step("fill", 1'b0, 1'b1, 1'b1);
        end
        check("fill_const", data_out, 8'hFF);
        step("discard", 1'b0, 1'b1, 1'b0);
        check("discard_const", data_out, 8'hFE);

        // Build 0x5A, then reset mid-stream, then shift from reset value.
        pat = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            step("build5a", 1'b0, 1'b1, pat[i]);
        end
        check("build5a_const", data_out, 8'h5A);
        step("midreset", 1'b1, 1'b1, 1'b1);
        check("midreset_const", data_out, 8'h00);
        step("after_reset", 1'b0, 1'b1, 1'b1);
        check("after_reset_const", data_out, 8'h01);

        // Reset pulse between edges must not touch the register.
        held = data_out;
        #1 reset_n = 1'b1;
        #1 check("async_rst_ignored", data_out, held);
        reset_n = 1'b0;
        step("after_glitch", 1'b0, 1'b0, 1'b1);
        check("after_glitch_const", data_out, 8'h01);

        // Gapped enables from zero.
        step("gap_rst", 1'b1, 1'b0, 1'b0);
        step("gap0", 1'b0, 1'b1, 1'b1);
        check("gap0_const", data_out, 8'h01);
        step("gap1", 1'b0, 1'b0, 1'b1);
        check("gap1_const", data_out, 8'h01);
        step("gap2", 1'b0, 1'b1, 1'b1);
        check("gap2_const", data_out, 8'h03);
        step("gap3", 1'b0, 1'b0, 1'b1);
        check("gap3_const", data_out, 8'h03);
        step("gap4", 1'b0, 1'b1, 1'b1);
        check("gap4_const", data_out, 8'h07);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shift_register
